// File: rtl/branch_predictor.sv
// Dynamic branch direction predictor: PHT of 2-bit saturating counters with
// static, bimodal and gshare indexing, a post-reset init sweep and statistics.
module branch_predictor #(
  parameter int unsigned PHT_DEPTH = 256,
  parameter int unsigned GHR_WIDTH = 8,
  parameter int unsigned MODE      = 2,
  parameter logic [1:0]  CTR_INIT  = 2'b01,
  localparam int unsigned IDX_W    = $clog2(PHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pcF,
  output logic             predict_takenF,
  output logic [IDX_W-1:0] predict_indexF,
  output logic             ready,
  input  logic             update_en,
  input  logic [IDX_W-1:0] update_index,
  input  logic             update_taken,
  input  logic             update_mispredict,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      mispredict_cnt
);

  typedef enum logic {INIT, RUN} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PHT_DEPTH - 1);

  state_e                 state;
  logic [IDX_W-1:0]       initPtr;
  logic [GHR_WIDTH-1:0]   ghr;
  logic [1:0]             pht [PHT_DEPTH];
  logic [IDX_W-1:0]       pcIdx;
  logic [1:0]             ctrOld;
  logic [1:0]             ctrNext;
  logic                   unusedPcBits;

  assign pcIdx        = pcF[IDX_W+1:2];
  assign unusedPcBits = ^{pcF[31:IDX_W+2], pcF[1:0]};

  always_comb begin
    predict_indexF = pcIdx;
    if (MODE == 2) predict_indexF = pcIdx ^ IDX_W'(ghr);
  end

  assign predict_takenF = (MODE != 0) && ready && pht[predict_indexF][1];

  always_comb begin
    ctrOld  = pht[update_index];
    ctrNext = ctrOld;
    if (update_taken && ctrOld != 2'b11)      ctrNext = ctrOld + 2'b01;
    else if (!update_taken && ctrOld != 2'b00) ctrNext = ctrOld - 2'b01;
  end

  // Table storage is not reset; the sweep below defines its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == INIT)                        pht[initPtr] <= CTR_INIT;
      else if (update_en && MODE != 0)          pht[update_index] <= ctrNext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= INIT;
      initPtr        <= '0;
      ghr            <= '0;
      ready          <= 1'b0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      case (state)
        INIT: begin
          initPtr <= initPtr + IDX_W'(1);
          if (initPtr == LAST_IDX) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (update_en) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (update_mispredict) mispredict_cnt <= mispredict_cnt + 32'd1;
            // Non-speculative history: shifts only on resolution.
            if (MODE == 2) ghr <= GHR_WIDTH'({ghr, update_taken});
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
